// File: rtl/pipe_rx_os_detect.sv
// Per-lane PIPE receive ordered-set detector: frames TS1/TS2 sets, publishes
// their fields, counts consecutive identical sets and discards SKP sets.
module pipe_rx_os_detect #(
    parameter int unsigned CONS_TARGET = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rxdata,
    input  logic       rxdatak,
    input  logic       rxvalid,
    input  logic       rxelecidle,
    output logic       ts_valid,
    output logic       ts_type,
    output logic [7:0] link_num,
    output logic       link_pad,
    output logic [7:0] lane_num,
    output logic       lane_pad,
    output logic [7:0] n_fts,
    output logic [7:0] rate_id,
    output logic [7:0] train_ctrl,
    output logic [3:0] cons_cnt,
    output logic       cons_hit,
    output logic       os_err
);

    typedef enum logic [1:0] {HUNT, FIELDS, TSID, SKIP} state_t;

    state_t     state, state_nx;
    logic [3:0] idx, idx_nx;
    logic       sh_type, sh_type_nx;
    logic [7:0] sh_link, sh_link_nx, sh_lane, sh_lane_nx;
    logic       sh_link_pad, sh_link_pad_nx, sh_lane_pad, sh_lane_pad_nx;
    logic [7:0] sh_nfts, sh_nfts_nx, sh_rate, sh_rate_nx, sh_ctrl, sh_ctrl_nx;
    logic       publish, err, clr, bad, same;
    logic [3:0] cons_nx;

    logic is_com, is_pad, is_skp, is_d;
    assign is_com = rxdatak && (rxdata == 8'hBC);
    assign is_pad = rxdatak && (rxdata == 8'hF7);
    assign is_skp = rxdatak && (rxdata == 8'h1C);
    assign is_d   = !rxdatak;

    always_comb begin
        state_nx       = state;
        idx_nx         = idx;
        sh_type_nx     = sh_type;
        sh_link_nx     = sh_link;
        sh_link_pad_nx = sh_link_pad;
        sh_lane_nx     = sh_lane;
        sh_lane_pad_nx = sh_lane_pad;
        sh_nfts_nx     = sh_nfts;
        sh_rate_nx     = sh_rate;
        sh_ctrl_nx     = sh_ctrl;
        publish        = 1'b0;
        err            = 1'b0;
        clr            = 1'b0;
        bad            = 1'b0;

        if (rxelecidle) begin
            state_nx = HUNT;
            idx_nx   = '0;
            clr      = 1'b1;
        end else if (!rxvalid) begin
            if (state == FIELDS || state == TSID) begin
                err      = 1'b1;
                clr      = 1'b1;
                state_nx = HUNT;
                idx_nx   = '0;
            end
        end else begin
            case (state)
                HUNT: begin
                    if (is_com) begin
                        state_nx = FIELDS;
                        idx_nx   = 4'd1;
                    end
                end
                SKIP: begin
                    if (is_com) begin
                        state_nx = FIELDS;
                        idx_nx   = 4'd1;
                    end else if (!is_skp) begin
                        state_nx = HUNT;
                        idx_nx   = '0;
                    end
                end
                FIELDS: begin
                    if (idx == 4'd1 && is_skp) begin
                        state_nx = SKIP;
                        idx_nx   = '0;
                    end else if (is_com) begin
                        err      = 1'b1;
                        clr      = 1'b1;
                        idx_nx   = 4'd1;
                    end else begin
                        case (idx)
                            4'd1: begin
                                bad            = rxdatak && !is_pad;
                                sh_link_pad_nx = is_pad;
                                sh_link_nx     = is_pad ? 8'h00 : rxdata;
                            end
                            4'd2: begin
                                bad            = rxdatak && !is_pad;
                                sh_lane_pad_nx = is_pad;
                                sh_lane_nx     = is_pad ? 8'h00 : rxdata;
                            end
                            4'd3: begin bad = rxdatak; sh_nfts_nx = rxdata; end
                            4'd4: begin bad = rxdatak; sh_rate_nx = rxdata; end
                            4'd5: begin bad = rxdatak; sh_ctrl_nx = rxdata; end
                            default: bad = 1'b1;
                        endcase
                        if (bad) begin
                            err      = 1'b1;
                            clr      = 1'b1;
                            state_nx = HUNT;
                            idx_nx   = '0;
                        end else if (idx == 4'd5) begin
                            state_nx = TSID;
                            idx_nx   = 4'd6;
                        end else begin
                            idx_nx = idx + 4'd1;
                        end
                    end
                end
                TSID: begin
                    if (is_com) begin
                        err      = 1'b1;
                        clr      = 1'b1;
                        state_nx = FIELDS;
                        idx_nx   = 4'd1;
                    end else begin
                        if (idx == 4'd6) begin
                            bad        = !(is_d && (rxdata == 8'h4A || rxdata == 8'h45));
                            sh_type_nx = (rxdata == 8'h45);
                        end else begin
                            bad = !(is_d && rxdata == (sh_type ? 8'h45 : 8'h4A));
                        end
                        if (bad) begin
                            err      = 1'b1;
                            clr      = 1'b1;
                            state_nx = HUNT;
                            idx_nx   = '0;
                        end else if (idx == 4'd15) begin
                            publish  = 1'b1;
                            state_nx = HUNT;
                            idx_nx   = '0;
                        end else begin
                            idx_nx = idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state_nx = HUNT;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // Shadows are complete at symbol 15, so they are compared against the published set directly.
    assign same = ({sh_type, sh_link, sh_link_pad, sh_lane, sh_lane_pad, sh_nfts, sh_rate, sh_ctrl} ==
                   {ts_type, link_num, link_pad, lane_num, lane_pad, n_fts, rate_id, train_ctrl})
                  && (cons_cnt != 4'd0);

    always_comb begin
        cons_nx = cons_cnt;
        if (clr)
            cons_nx = '0;
        else if (publish)
            cons_nx = !same ? 4'd1 : ((cons_cnt == 4'd15) ? 4'd15 : cons_cnt + 4'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HUNT;
            idx         <= '0;
            sh_type     <= 1'b0;
            sh_link     <= '0;
            sh_link_pad <= 1'b0;
            sh_lane     <= '0;
            sh_lane_pad <= 1'b0;
            sh_nfts     <= '0;
            sh_rate     <= '0;
            sh_ctrl     <= '0;
            ts_valid    <= 1'b0;
            os_err      <= 1'b0;
            ts_type     <= 1'b0;
            link_num    <= '0;
            link_pad    <= 1'b0;
            lane_num    <= '0;
            lane_pad    <= 1'b0;
            n_fts       <= '0;
            rate_id     <= '0;
            train_ctrl  <= '0;
            cons_cnt    <= '0;
            cons_hit    <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            sh_type     <= sh_type_nx;
            sh_link     <= sh_link_nx;
            sh_link_pad <= sh_link_pad_nx;
            sh_lane     <= sh_lane_nx;
            sh_lane_pad <= sh_lane_pad_nx;
            sh_nfts     <= sh_nfts_nx;
            sh_rate     <= sh_rate_nx;
            sh_ctrl     <= sh_ctrl_nx;
            ts_valid    <= publish;
            os_err      <= err;
            cons_cnt    <= cons_nx;
            cons_hit    <= (32'(cons_nx) >= CONS_TARGET);
            if (publish) begin
                ts_type    <= sh_type;
                link_num   <= sh_link;
                link_pad   <= sh_link_pad;
                lane_num   <= sh_lane;
                lane_pad   <= sh_lane_pad;
                n_fts      <= sh_nfts;
                rate_id    <= sh_rate;
                train_ctrl <= sh_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_pipe_rx_os_detect.sv
// Directed bench for pipe_rx_os_detect: expected TS/error pulses are queued as
// symbols are driven and compared cycle by cycle against the DUT outputs.
module tb_pipe_rx_os_detect;

    localparam int TARGET = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rxdata;
    logic       rxdatak, rxvalid, rxelecidle;
    logic       ts_valid, ts_type, link_pad, lane_pad, cons_hit, os_err;
    logic [7:0] link_num, lane_num, n_fts, rate_id, train_ctrl;
    logic [3:0] cons_cnt;

    always #5 clk = ~clk;

    pipe_rx_os_detect #(.CONS_TARGET(TARGET)) dut (
        .clk(clk), .reset_n(reset_n),
        .rxdata(rxdata), .rxdatak(rxdatak), .rxvalid(rxvalid), .rxelecidle(rxelecidle),
        .ts_valid(ts_valid), .ts_type(ts_type),
        .link_num(link_num), .link_pad(link_pad),
        .lane_num(lane_num), .lane_pad(lane_pad),
        .n_fts(n_fts), .rate_id(rate_id), .train_ctrl(train_ctrl),
        .cons_cnt(cons_cnt), .cons_hit(cons_hit), .os_err(os_err)
    );

    typedef struct {
        logic        is_err;
        logic [42:0] fields;
        logic [3:0]  cons;
        logic        hit;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [42:0] m_prev;
    logic [3:0]  m_cons;

    function automatic logic [42:0] dut_fields();
        return {ts_type, link_num, link_pad, lane_num, lane_pad, n_fts, rate_id, train_ctrl};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (sb.size() == 0) begin
            check("no_pulse", {62'd0, ts_valid, os_err}, 64'd0);
        end else begin
            e = sb.pop_front();
            check("pulse_kind", {62'd0, ts_valid, os_err}, e.is_err ? 64'd1 : 64'd2);
            check("fields", {21'd0, dut_fields()}, {21'd0, e.fields});
            check("cons_cnt", {60'd0, cons_cnt}, {60'd0, e.cons});
            check("cons_hit", {63'd0, cons_hit}, {63'd0, e.hit});
        end
    endtask

    task automatic drive(input logic k, input logic [7:0] d, input logic v, input logic ei);
        rxdatak    = k;
        rxdata     = d;
        rxvalid    = v;
        rxelecidle = ei;
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    // mode: 0 clean, 1 replace symbol 'bad' with bk/bd, 2 rxvalid low at 'bad', 3 elecidle at 'bad'
    task automatic send_ts(input logic t, input logic [7:0] link, input logic lp,
                           input logic [7:0] lane, input logic lnp,
                           input logic [7:0] nf, input logic [7:0] rt, input logic [7:0] ct,
                           input int start, input int bad, input int mode,
                           input logic bk, input logic [7:0] bd);
        logic [42:0] f;
        logic [3:0]  c;
        logic        k;
        logic [7:0]  d;
        f = {t, lp ? 8'h00 : link, lp, lnp ? 8'h00 : lane, lnp, nf, rt, ct};
        for (int s = start; s <= 15; s++) begin
            case (s)
                0:       begin k = 1'b1; d = 8'hBC; end
                1:       begin k = lp;   d = lp ? 8'hF7 : link; end
                2:       begin k = lnp;  d = lnp ? 8'hF7 : lane; end
                3:       begin k = 1'b0; d = nf; end
                4:       begin k = 1'b0; d = rt; end
                5:       begin k = 1'b0; d = ct; end
                default: begin k = 1'b0; d = t ? 8'h45 : 8'h4A; end
            endcase
            if (s == bad) begin
                if (mode == 3) begin
                    m_cons = 4'd0;
                    drive(k, d, 1'b1, 1'b1);
                end else begin
                    sb.push_back('{1'b1, m_prev, 4'd0, 1'b0});
                    m_cons = 4'd0;
                    if (mode == 2) drive(k, d, 1'b0, 1'b0);
                    else           drive(bk, bd, 1'b1, 1'b0);
                end
                return;
            end
            if (s == 15) begin
                c = (f == m_prev && m_cons != 4'd0) ?
                    ((m_cons == 4'd15) ? 4'd15 : m_cons + 4'd1) : 4'd1;
                m_cons = c;
                m_prev = f;
                sb.push_back('{1'b0, f, c, int'(c) >= TARGET});
            end
            drive(k, d, 1'b1, 1'b0);
        end
    endtask

    task automatic ts1_pad();
        send_ts(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h20, 8'h02, 8'h00, 0, -1, 0, 1'b0, 8'h00);
    endtask

    task automatic ts2_pad();
        send_ts(1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 8'h20, 8'h02, 8'h00, 0, -1, 0, 1'b0, 8'h00);
    endtask

    task automatic ts2_num();
        send_ts(1'b1, 8'h01, 1'b0, 8'h02, 1'b0, 8'h20, 8'h02, 8'h00, 0, -1, 0, 1'b0, 8'h00);
    endtask

    initial begin
        reset_n    = 1'b0;
        rxdata     = 8'h00;
        rxdatak    = 1'b0;
        rxvalid    = 1'b0;
        rxelecidle = 1'b0;
        m_prev     = '0;
        m_cons     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fields", {21'd0, dut_fields()}, 64'd0);
        check("rst_misc", {57'd0, ts_valid, os_err, cons_cnt, cons_hit}, 64'd0);
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // eight back-to-back TS1: count 1..8, cons_hit with the eighth
        repeat (8) ts1_pad();

        // electrical idle clears the count, then TS1 x3 and TS2 x2
        m_cons = 4'd0;
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check("ei_cons", {60'd0, cons_cnt}, 64'd0);
        repeat (3) ts1_pad();
        repeat (2) ts2_pad();

        // SKP set between identical TS1 sets
        ts1_pad();
        drive(1'b1, 8'hBC, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 8'h1C, 1'b1, 1'b0);
        ts1_pad();

        // ID mismatch at symbol 10, then recovery
        send_ts(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h20, 8'h02, 8'h00, 0, 10, 1, 1'b0, 8'h45);
        ts1_pad();

        // rxvalid drop at symbol 4, then elecidle during a later set
        send_ts(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h20, 8'h02, 8'h00, 0, 4, 2, 1'b0, 8'h00);
        send_ts(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h20, 8'h02, 8'h00, 0, 9, 3, 1'b0, 8'h00);
        check("ei_mid_cons", {59'd0, cons_cnt, cons_hit}, 64'd0);
        check("ei_mid_fields", {21'd0, dut_fields()}, {21'd0, m_prev});

        // COM mid-set resyncs straight into a new set's symbol 1
        ts1_pad();
        send_ts(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h20, 8'h02, 8'h00, 0, 7, 1, 1'b1, 8'hBC);
        send_ts(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h20, 8'h02, 8'h00, 1, -1, 0, 1'b0, 8'h00);

        // twenty identical TS2 saturate at 15, then reset mid-set
        repeat (20) ts2_num();
        drive(1'b1, 8'hBC, 1'b1, 1'b0);
        drive(1'b0, 8'h01, 1'b1, 1'b0);
        drive(1'b0, 8'h02, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_fields", {21'd0, dut_fields()}, 64'd0);
        check("midrst_misc", {57'd0, ts_valid, os_err, cons_cnt, cons_hit}, 64'd0);
        m_prev = '0;
        m_cons = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        ts2_num();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
